// File: rtl/simple_proc_prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, widths and the
// fetch range helper used by the top level.
package simple_proc_prog_loader_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ARM  = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // A fetch is out of range when the address reaches the stored program length.
  function automatic logic fetch_past_end(input logic [ADDR_W-1:0] addr,
                                          input logic [LEN_W-1:0]  len);
    return ({1'b0, addr} >= len);
  endfunction

endpackage

// File: rtl/simple_proc_prog_loader_ram.sv
// Program memory: one write port, one synchronous read port, no reset.
// The read register holds its value whenever the read enable is low.
module prog_ram_1024x16
  import simple_proc_prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Synchronous read port
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/simple_proc_prog_loader.sv
// Program loader: accepts a host download into program RAM, pulses start,
// then serves processor fetches with one-cycle latency.
module simple_proc_prog_loader
  import simple_proc_prog_loader_pkg::*;
#(
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_begin,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ram_read_en,
  output logic [WORD_W-1:0] data_in,
  output logic              start,
  output logic [LEN_W-1:0]  prog_len,
  output logic              loading,
  output logic              past_end
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic                halt_sel;
  logic [WORD_W-1:0]   ram_q;
  logic                start_nxt;
  logic                loading_nxt;
  logic                load_ready_nxt;

  logic write_fire;
  logic word_is_last;
  logic abort_run;
  logic fetch;
  logic fetch_past;
  logic fetch_hit;
  logic enter_load;

  assign write_fire   = load_valid && (state == ST_LOAD);
  // The top address ends a download even without load_last, so the pointer never wraps.
  assign word_is_last = load_last || (wr_ptr == LAST_ADDR);
  assign abort_run    = (state == ST_RUN) && load_begin;
  assign fetch        = ram_read_en && ((state == ST_ARM) || (state == ST_RUN)) && !abort_run;
  assign fetch_past   = fetch_past_end(pc, prog_len);
  assign fetch_hit    = fetch && !fetch_past;
  assign enter_load   = (state != ST_LOAD) && (next_state == ST_LOAD);

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (load_begin) begin
          next_state = ST_LOAD;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (write_fire && word_is_last) begin
          next_state = ST_ARM;
        end else begin
          next_state = ST_LOAD;
        end
      end
      ST_ARM: begin
        next_state = ST_RUN;
      end
      ST_RUN: begin
        if (load_begin) begin
          next_state = ST_LOAD;
        end else begin
          next_state = ST_RUN;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Status outputs are computed from the upcoming state so they can be registered
  always_comb begin
    start_nxt      = 1'b0;
    loading_nxt    = 1'b0;
    load_ready_nxt = 1'b0;
    case (next_state)
      ST_LOAD: begin
        loading_nxt    = 1'b1;
        load_ready_nxt = 1'b1;
      end
      ST_ARM: begin
        start_nxt = 1'b1;
      end
      default: begin
        start_nxt      = 1'b0;
        loading_nxt    = 1'b0;
        load_ready_nxt = 1'b0;
      end
    endcase
  end

  // State and registered status outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      start      <= 1'b0;
      loading    <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      state      <= next_state;
      start      <= start_nxt;
      loading    <= loading_nxt;
      load_ready <= load_ready_nxt;
    end
  end

  // Write pointer and committed program length
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr   <= '0;
      prog_len <= '0;
    end else begin
      if (enter_load) begin
        wr_ptr <= '0;
      end else if (write_fire && !word_is_last) begin
        wr_ptr <= wr_ptr + 10'd1;
      end
      if (write_fire && word_is_last) begin
        prog_len <= {1'b0, wr_ptr} + 11'd1;
      end
    end
  end

  // Fetch result selection; halt_sel masks the RAM output with HALT_WORD
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      halt_sel <= 1'b1;
      past_end <= 1'b0;
    end else begin
      if (abort_run) begin
        halt_sel <= 1'b1;
      end else if (fetch) begin
        halt_sel <= fetch_past;
        past_end <= fetch_past;
      end
    end
  end

  assign data_in = halt_sel ? HALT_WORD : ram_q;

  prog_ram_1024x16 #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (write_fire),
    .waddr (wr_ptr),
    .wdata (load_data),
    .re    (fetch_hit),
    .raddr (pc),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_simple_proc_prog_loader.sv
// Self-checking bench for simple_proc_prog_loader: randomized downloads and
// fetches compared against a word-array model of the stored program.
module tb_simple_proc_prog_loader;

  localparam logic [15:0] HALT = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_begin;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [9:0]  pc;
  logic        ram_read_en;
  logic [15:0] data_in;
  logic        start;
  logic [10:0] prog_len;
  logic        loading;
  logic        past_end;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] model_mem [1024];
  int          model_len = 0;
  logic [15:0] exp_data = HALT;
  logic        exp_past = 1'b0;

  simple_proc_prog_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_begin  (load_begin),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .pc          (pc),
    .ram_read_en (ram_read_en),
    .data_in     (data_in),
    .start       (start),
    .prog_len    (prog_len),
    .loading     (loading),
    .past_end    (past_end)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [15:0] ref_word(input int a);
    return (a < model_len) ? model_mem[a] : HALT;
  endfunction

  // Apply a fetch at the next edge and update the expected outputs.
  task automatic apply_fetch(input int a, input bit en);
    pc = 10'(a);
    ram_read_en = en;
    @(negedge clk);
    if (en) begin
      exp_data = ref_word(a);
      exp_past = (a >= model_len);
    end
  endtask

  // Host download driver; records handshaked words in the model.
  task automatic run_download(input int n, input bit use_last, input int valid_pct,
                              input bit send_begin, input logic [15:0] step,
                              output int accepted);
    int idx;
    int cyc;
    bit v;
    logic [15:0] w;
    logic ready_now;
    idx = 0;
    cyc = 0;
    if (send_begin) begin
      load_begin = 1'b1;
      @(negedge clk);
      load_begin = 1'b0;
    end
    while (idx < n && cyc < n * 4 + 64) begin
      v = ($urandom_range(99) < valid_pct);
      w = (step != 16'h0000) ? 16'(step * (idx + 1)) : (16'($urandom()) | 16'h0001);
      load_valid = v;
      load_data  = w;
      load_last  = use_last && (idx == n - 1);
      ready_now  = load_ready;
      @(negedge clk);
      load_begin = 1'b0;
      if (v && ready_now) begin
        model_mem[idx] = w;
        idx++;
      end
      cyc++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    accepted   = idx;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    load_begin = 1'b0; load_valid = 1'b0; load_data = 16'h0000; load_last = 1'b0;
    pc = 10'd0; ram_read_en = 1'b0;
    #3;
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL reset_load_ready: got %0b want 0", load_ready); end
    n_cmp++; if (loading !== 1'b0) begin n_bad++; $display("FAIL reset_loading: got %0b want 0", loading); end
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %0b want 0", start); end
    n_cmp++; if (prog_len !== 11'd0) begin n_bad++; $display("FAIL reset_prog_len: got %0d want 0", prog_len); end
    n_cmp++; if (data_in !== HALT) begin n_bad++; $display("FAIL reset_data_in: got %h want %h", data_in, HALT); end
    n_cmp++; if (past_end !== 1'b0) begin n_bad++; $display("FAIL reset_past_end: got %0b want 0", past_end); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_download();
    int acc;
    run_download(3, 1'b1, 100, 1'b1, 16'h1111, acc);
    model_len = 3;
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL basic_accepted: got %0d want 3", acc); end
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL basic_start_high: got %0b want 1", start); end
    n_cmp++; if (prog_len !== 11'd3) begin n_bad++; $display("FAIL basic_prog_len: got %0d want 3", prog_len); end
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_arm: got %0b want 0", load_ready); end
    @(negedge clk);
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL basic_start_low: got %0b want 0", start); end
    for (int i = 0; i < 4; i++) begin
      apply_fetch(i, 1'b1);
      n_cmp++; if (data_in !== exp_data) begin n_bad++; $display("FAIL basic_fetch_data pc=%0d: got %h want %h", i, data_in, exp_data); end
      n_cmp++; if (past_end !== exp_past) begin n_bad++; $display("FAIL basic_fetch_past pc=%0d: got %0b want %0b", i, past_end, exp_past); end
    end
    apply_fetch(1, 1'b0);
    n_cmp++; if (data_in !== exp_data) begin n_bad++; $display("FAIL basic_hold_data: got %h want %h", data_in, exp_data); end
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL basic_start_run: got %0b want 0", start); end
  endtask

  task automatic test_random_handshake();
    int acc;
    int a;
    bit en;
    run_download(20, 1'b1, 50, 1'b1, 16'h0000, acc);
    model_len = 20;
    n_cmp++; if (acc != 20) begin n_bad++; $display("FAIL rand_accepted: got %0d want 20", acc); end
    n_cmp++; if (prog_len !== 11'd20) begin n_bad++; $display("FAIL rand_prog_len: got %0d want 20", prog_len); end
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL rand_start: got %0b want 1", start); end
    for (int i = 0; i < 20; i++) begin
      apply_fetch(i, 1'b1);
      n_cmp++; if (data_in !== exp_data) begin n_bad++; $display("FAIL rand_readback pc=%0d: got %h want %h", i, data_in, exp_data); end
    end
    for (int k = 0; k < 40; k++) begin
      a  = $urandom_range(29);
      en = ($urandom_range(3) != 0);
      apply_fetch(a, en);
      n_cmp++; if (data_in !== exp_data) begin n_bad++; $display("FAIL rand_fetch_data pc=%0d en=%0b: got %h want %h", a, en, data_in, exp_data); end
      n_cmp++; if (past_end !== exp_past) begin n_bad++; $display("FAIL rand_fetch_past pc=%0d en=%0b: got %0b want %0b", a, en, past_end, exp_past); end
    end
    ram_read_en = 1'b0;
  endtask

  task automatic test_full_depth();
    int acc;
    logic [15:0] first;
    run_download(1024, 1'b0, 100, 1'b1, 16'h0000, acc);
    model_len = 1024;
    first = model_mem[0];
    n_cmp++; if (acc != 1024) begin n_bad++; $display("FAIL full_accepted: got %0d want 1024", acc); end
    n_cmp++; if (prog_len !== 11'd1024) begin n_bad++; $display("FAIL full_prog_len: got %0d want 1024", prog_len); end
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL full_start: got %0b want 1", start); end
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_arm: got %0b want 0", load_ready); end
    load_valid = 1'b1;
    load_data  = ~first;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_after cyc=%0d: got %0b want 0", i, load_ready); end
    end
    load_valid = 1'b0;
    apply_fetch(0, 1'b1);
    n_cmp++; if (data_in !== first) begin n_bad++; $display("FAIL full_word0: got %h want %h", data_in, first); end
    apply_fetch(1023, 1'b1);
    n_cmp++; if (data_in !== exp_data) begin n_bad++; $display("FAIL full_word1023: got %h want %h", data_in, exp_data); end
    n_cmp++; if (past_end !== 1'b0) begin n_bad++; $display("FAIL full_past_1023: got %0b want 0", past_end); end
    ram_read_en = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int acc;
    run_download(5, 1'b0, 100, 1'b1, 16'h0000, acc);
    n_cmp++; if (loading !== 1'b1) begin n_bad++; $display("FAIL midrst_loading_before: got %0b want 1", loading); end
    #2 rst_n = 1'b1;
    #1;
    model_len = 0;
    exp_data  = HALT;
    exp_past  = 1'b0;
    n_cmp++; if (loading !== 1'b0) begin n_bad++; $display("FAIL midrst_loading: got %0b want 0", loading); end
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_load_ready: got %0b want 0", load_ready); end
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL midrst_start: got %0b want 0", start); end
    n_cmp++; if (prog_len !== 11'd0) begin n_bad++; $display("FAIL midrst_prog_len: got %0d want 0", prog_len); end
    n_cmp++; if (data_in !== HALT) begin n_bad++; $display("FAIL midrst_data_in: got %h want %h", data_in, HALT); end
    n_cmp++; if (past_end !== 1'b0) begin n_bad++; $display("FAIL midrst_past_end: got %0b want 0", past_end); end
    @(negedge clk);
    rst_n = 1'b0;
    apply_fetch(0, 1'b1);
    n_cmp++; if (prog_len !== 11'd0) begin n_bad++; $display("FAIL midrst_len_after: got %0d want 0", prog_len); end
    n_cmp++; if (data_in !== HALT) begin n_bad++; $display("FAIL midrst_fetch0: got %h want %h", data_in, HALT); end
    ram_read_en = 1'b0;
  endtask

  task automatic test_abort_reload();
    int acc;
    run_download(4, 1'b1, 100, 1'b1, 16'h0000, acc);
    model_len = 4;
    @(negedge clk);
    apply_fetch(1, 1'b1);
    n_cmp++; if (data_in !== exp_data) begin n_bad++; $display("FAIL abort_prefetch: got %h want %h", data_in, exp_data); end
    load_begin = 1'b1;
    apply_fetch(2, 1'b1);
    exp_data = HALT;
    exp_past = (1 >= model_len);
    n_cmp++; if (data_in !== HALT) begin n_bad++; $display("FAIL abort_halt: got %h want %h", data_in, HALT); end
    n_cmp++; if (loading !== 1'b1) begin n_bad++; $display("FAIL abort_loading: got %0b want 1", loading); end
    n_cmp++; if (prog_len !== 11'd4) begin n_bad++; $display("FAIL abort_len_hold: got %0d want 4", prog_len); end
    ram_read_en = 1'b0;
    // load_begin stays high into the first LOAD word and must be ignored there
    run_download(2, 1'b1, 100, 1'b0, 16'h0000, acc);
    model_len = 2;
    n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL reload_accepted: got %0d want 2", acc); end
    n_cmp++; if (prog_len !== 11'd2) begin n_bad++; $display("FAIL reload_prog_len: got %0d want 2", prog_len); end
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL reload_start: got %0b want 1", start); end
    n_cmp++; if (data_in !== HALT) begin n_bad++; $display("FAIL reload_data_hold: got %h want %h", data_in, HALT); end
    @(negedge clk);
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reload_start_low: got %0b want 0", start); end
    for (int i = 0; i < 4; i++) begin
      apply_fetch(i, 1'b1);
      n_cmp++; if (data_in !== exp_data) begin n_bad++; $display("FAIL reload_fetch pc=%0d: got %h want %h", i, data_in, exp_data); end
      n_cmp++; if (past_end !== exp_past) begin n_bad++; $display("FAIL reload_past pc=%0d: got %0b want %0b", i, past_end, exp_past); end
    end
    ram_read_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_download();
    test_random_handshake();
    test_full_depth();
    test_reset_mid_load();
    test_abort_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simple_proc_prog_loader.md
SIMPLE_PROC_PROG_LOADER -- requirements
Module: simple_proc_prog_loader

Interface
REQ-001 Parameter DEPTH, default 1024, program memory depth in 16-bit words (matches 10-bit pc).
REQ-002 Parameter HALT_WORD, default 16'h0000, word returned for reads at or beyond program length.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-high (asserted = 1); the name is kept as the codebase does.
REQ-005 load_begin  input  1  single-cycle request to start a new program download.
REQ-006 load_valid  input  1  host word valid.
REQ-007 load_data  input  16  host instruction word.
REQ-008 load_last  input  1  qualifies the final word of a download.
REQ-009 load_ready  output  1  loader accepts a word this cycle.
REQ-010 pc  input  10  processor fetch address.
REQ-011 ram_read_en  input  1  processor fetch enable.
REQ-012 data_in  output  16  instruction word delivered to the processor.
REQ-013 start  output  1  one-cycle pulse that launches the processor.
REQ-014 prog_len  output  11  number of words stored by the last completed download (0..1024).
REQ-015 loading  output  1  high while in LOAD.
REQ-016 past_end  output  1  the most recent fetch addressed pc >= prog_len.

Function
REQ-017 FSM states: IDLE, LOAD, ARM, RUN.
REQ-018 IDLE->LOAD on load_begin; RUN->LOAD on load_begin; load_begin in LOAD or ARM is ignored.
REQ-019 On entry to LOAD, the write pointer clears to 0, and prog_len holds its old value until completion.
REQ-020 load_ready = 1 only in LOAD; a word is written when load_valid && load_ready, at the write pointer, and the pointer increments by 1.
REQ-021 A write with load_last = 1 sets prog_len = pointer+1 and moves to ARM on the same edge.
REQ-022 A write at pointer DEPTH-1 without load_last is treated as the last word: prog_len = DEPTH, go to ARM, with no wrap and no overwrite of word 0.
REQ-023 ARM lasts exactly one cycle with start = 1, then moves to RUN; start is 0 in every other state.
REQ-024 Fetch: when ram_read_en = 1 at an edge in ARM or RUN, data_in updates at that edge to mem[pc] if pc < prog_len, else to HALT_WORD; this is 1-cycle read latency.
REQ-025 The fetch in REQ-024 sets past_end = (pc >= prog_len).
REQ-026 When ram_read_en = 0, or in IDLE or LOAD, data_in and past_end hold their values.
REQ-027 A load_begin in RUN aborts the run: data_in is forced to HALT_WORD on the same edge, so the processor sees no partial program.
REQ-028 Memory contents are not cleared by reset or by reload; words beyond prog_len are unreachable through data_in.

Reset
REQ-029 Reset asserted forces, immediately and asynchronously: state = IDLE, write pointer = 0, prog_len = 0, data_in = HALT_WORD, start = 0, load_ready = 0, loading = 0, past_end = 0.
REQ-030 Reset asserted mid-LOAD discards the partial download; prog_len stays 0 after release.
REQ-031 Memory array has no reset.

Structure
REQ-032 A shared package holds the FSM state encoding (2-bit: IDLE = 0, LOAD = 1, ARM = 2, RUN = 3), the HALT_WORD default, and the address width constant 10.
REQ-033 A single sub-module, prog_ram_1024x16 (one write port, one synchronous read port, no reset), holds the memory; FSM, pointer and output registers live at top level.

Verification
REQ-034 Download of 3 words (16'h1111, 16'h2222, 16'h3333, last on the third) -> prog_len = 3, start pulses exactly 1 cycle, 1 cycle after the last write.
REQ-035 In RUN, ram_read_en = 1 with pc = 0, 1, 2, 3 on consecutive cycles -> data_in = 1111, 2222, 3333, 0000 one cycle later each; past_end = 1 only for pc = 3.
REQ-036 load_valid toggled randomly, with load_ready observed -> only handshaked words are stored; readback matches in order.
REQ-037 1024 words written with no load_last -> prog_len = 1024, ARM entered, load_ready = 0 afterwards; word 0 still holds its original value.
REQ-038 Reset asserted after 5 of 10 words -> all outputs take reset values without waiting for a clock edge; after release, prog_len = 0 and a fetch at pc = 0 returns HALT_WORD.
REQ-039 load_begin during RUN -> data_in = HALT_WORD on the next edge; a new 2-word download leaves prog_len = 2 and issues a fresh start pulse.
